reorder_buffer: RTL and testbench

In-order commit stage of the out-of-order core: a 16-entry circular reorder buffer that hands out the 4-bit rename tags used by the register file, collects results from the CDB and retires one instruction per cycle. It sits directly downstream of the CDB and upstream of the register file. It drives the register file's commit inputs (update flag, dest, value, rename) and the branch-mispredict flush.

---
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 tb/tb_reorder_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: hands out rename tags, collects CDB
// results and retires one instruction per cycle in program order.
module reorder_buffer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_dest,
    input  logic        alloc_is_store,
    input  logic        alloc_is_branch,
    input  logic        alloc_pred_taken,
    input  logic [31:0] alloc_value,
    output logic        rob_full,
    output logic [3:0]  alloc_id,
    input  logic        simple_ins_commit,
    input  logic [3:0]  simple_ins_rename,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_rename,
    input  logic [31:0] cdb_value,
    input  logic        cdb_taken,
    input  logic [31:0] cdb_target,
    output logic        register_update_flag,
    output logic [4:0]  register_commit_dest,
    output logic [31:0] register_commit_value,
    output logic [3:0]  rename_of_commit_ins,
    output logic        store_commit_flag,
    output logic [3:0]  store_commit_rename,
    output logic        register_flush,
    output logic [31:0] flush_pc
);

    localparam int TW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] is_store_q;
    logic [DEPTH-1:0] is_branch_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] taken_q;
    logic [4:0]       dest_q   [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic [TW:0]   count;

    logic do_commit;
    logic mispredict;
    logic do_alloc;
    logic cdb_hit;
    logic simple_hit;

    assign rob_full = (count == (TW+1)'(DEPTH));
    assign alloc_id = tail;

    assign do_commit  = busy[head] & ready[head];
    assign mispredict = do_commit & is_branch_q[head]
                      & (taken_q[head] != pred_q[head]);
    assign do_alloc   = alloc_valid & ~rob_full;
    assign cdb_hit    = cdb_valid & busy[cdb_rename];
    assign simple_hit = simple_ins_commit & busy[simple_ins_rename];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy                  <= '0;
            ready                 <= '0;
            is_store_q            <= '0;
            is_branch_q           <= '0;
            pred_q                <= '0;
            taken_q               <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            head                  <= '0;
            tail                  <= '0;
            count                 <= '0;
            register_update_flag  <= 1'b0;
            register_commit_dest  <= '0;
            register_commit_value <= '0;
            rename_of_commit_ins  <= '0;
            store_commit_flag     <= 1'b0;
            store_commit_rename   <= '0;
            register_flush        <= 1'b0;
            flush_pc              <= '0;
        end else begin
            register_update_flag <= 1'b0;
            store_commit_flag    <= 1'b0;
            register_flush       <= 1'b0;
            if (rdy) begin
                if (do_commit) begin
                    if (!is_store_q[head] && dest_q[head] != '0) begin
                        register_update_flag  <= 1'b1;
                        register_commit_dest  <= dest_q[head];
                        register_commit_value <= value_q[head];
                        rename_of_commit_ins  <= head;
                    end
                    if (is_store_q[head]) begin
                        store_commit_flag   <= 1'b1;
                        store_commit_rename <= head;
                    end
                    if (mispredict) begin
                        register_flush <= 1'b1;
                        flush_pc       <= target_q[head];
                    end
                end
                // A flush wipes every same-cycle write, including younger allocs
                if (mispredict) begin
                    busy  <= '0;
                    ready <= '0;
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                end else begin
                    if (simple_hit) begin
                        ready[simple_ins_rename] <= 1'b1;
                    end
                    if (cdb_hit) begin
                        value_q[cdb_rename]  <= cdb_value;
                        taken_q[cdb_rename]  <= cdb_taken;
                        target_q[cdb_rename] <= cdb_target;
                        ready[cdb_rename]    <= 1'b1;
                    end
                    if (do_commit) begin
                        busy[head]  <= 1'b0;
                        ready[head] <= 1'b0;
                        head        <= head + 1'b1;
                    end
                    if (do_alloc) begin
                        busy[tail]        <= 1'b1;
                        ready[tail]       <= 1'b0;
                        dest_q[tail]      <= alloc_dest;
                        is_store_q[tail]  <= alloc_is_store;
                        is_branch_q[tail] <= alloc_is_branch;
                        pred_q[tail]      <= alloc_pred_taken;
                        value_q[tail]     <= alloc_value;
                        tail              <= tail + 1'b1;
                    end
                    count <= count + {{TW{1'b0}}, do_alloc}
                                   - {{TW{1'b0}}, do_commit};
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed stimulus pushes expected
// commits, a negedge monitor pops and compares each commit/flush pulse.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_is_store;
    logic        alloc_is_branch;
    logic        alloc_pred_taken;
    logic [31:0] alloc_value;
    logic        rob_full;
    logic [3:0]  alloc_id;
    logic        simple_ins_commit;
    logic [3:0]  simple_ins_rename;
    logic        cdb_valid;
    logic [3:0]  cdb_rename;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic        register_update_flag;
    logic [4:0]  register_commit_dest;
    logic [31:0] register_commit_value;
    logic [3:0]  rename_of_commit_ins;
    logic        store_commit_flag;
    logic [3:0]  store_commit_rename;
    logic        register_flush;
    logic [31:0] flush_pc;

    reorder_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .alloc_valid           (alloc_valid),
        .alloc_dest            (alloc_dest),
        .alloc_is_store        (alloc_is_store),
        .alloc_is_branch       (alloc_is_branch),
        .alloc_pred_taken      (alloc_pred_taken),
        .alloc_value           (alloc_value),
        .rob_full              (rob_full),
        .alloc_id              (alloc_id),
        .simple_ins_commit     (simple_ins_commit),
        .simple_ins_rename     (simple_ins_rename),
        .cdb_valid             (cdb_valid),
        .cdb_rename            (cdb_rename),
        .cdb_value             (cdb_value),
        .cdb_taken             (cdb_taken),
        .cdb_target            (cdb_target),
        .register_update_flag  (register_update_flag),
        .register_commit_dest  (register_commit_dest),
        .register_commit_value (register_commit_value),
        .rename_of_commit_ins  (rename_of_commit_ins),
        .store_commit_flag     (store_commit_flag),
        .store_commit_rename   (store_commit_rename),
        .register_flush        (register_flush),
        .flush_pc              (flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [4:0]  dest;
        logic [31:0] val;
        logic [3:0]  tag;
        logic        st;
        logic [3:0]  st_tag;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk_reg(input logic [4:0] d, input logic [31:0] v,
                                    input logic [3:0] t);
        exp_t e;
        e = '{1'b1, d, v, t, 1'b0, 4'd0, 1'b0, 32'd0};
        return e;
    endfunction

    function automatic exp_t mk_store(input logic [3:0] t);
        exp_t e;
        e = '{1'b0, 5'd0, 32'd0, 4'd0, 1'b1, t, 1'b0, 32'd0};
        return e;
    endfunction

    function automatic exp_t mk_flush(input logic [31:0] p);
        exp_t e;
        e = '{1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, p};
        return e;
    endfunction

    // Monitor: every pulse must match the oldest expected commit
    always @(negedge clk) begin
        if (rst && (register_update_flag || store_commit_flag || register_flush)) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_commit: actual upd=%0b dest=%0d tag=%0d st=%0b fl=%0b, required no pulse",
                         register_update_flag, register_commit_dest,
                         rename_of_commit_ins, store_commit_flag, register_flush);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_upd", 32'(register_update_flag), 32'(mon_e.upd));
                if (mon_e.upd) begin
                    check("commit_dest", 32'(register_commit_dest), 32'(mon_e.dest));
                    check("commit_value", register_commit_value, mon_e.val);
                    check("commit_tag", 32'(rename_of_commit_ins), 32'(mon_e.tag));
                end
                check("commit_store", 32'(store_commit_flag), 32'(mon_e.st));
                if (mon_e.st)
                    check("store_tag", 32'(store_commit_rename), 32'(mon_e.st_tag));
                check("commit_flush", 32'(register_flush), 32'(mon_e.fl));
                if (mon_e.fl)
                    check("flush_pc", flush_pc, mon_e.pc);
            end
        end
    end

    task automatic do_alloc(input logic [4:0] d, input logic st, input logic br,
                            input logic pt, input logic [31:0] v);
        alloc_valid      = 1'b1;
        alloc_dest       = d;
        alloc_is_store   = st;
        alloc_is_branch  = br;
        alloc_pred_taken = pt;
        alloc_value      = v;
        @(negedge clk);
        alloc_valid      = 1'b0;
        alloc_is_store   = 1'b0;
        alloc_is_branch  = 1'b0;
        alloc_pred_taken = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] t, input logic [31:0] v,
                          input logic tk, input logic [31:0] tgt);
        cdb_valid  = 1'b1;
        cdb_rename = t;
        cdb_value  = v;
        cdb_taken  = tk;
        cdb_target = tgt;
        @(negedge clk);
        cdb_valid  = 1'b0;
    endtask

    task automatic do_simple(input logic [3:0] t);
        simple_ins_commit = 1'b1;
        simple_ins_rename = t;
        @(negedge clk);
        simple_ins_commit = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sync_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rob_full"}, 32'(rob_full), 32'd0);
        check({tag, "_alloc_id"}, 32'(alloc_id), 32'd0);
        check({tag, "_upd"}, 32'(register_update_flag), 32'd0);
        check({tag, "_dest"}, 32'(register_commit_dest), 32'd0);
        check({tag, "_value"}, register_commit_value, 32'd0);
        check({tag, "_rename"}, 32'(rename_of_commit_ins), 32'd0);
        check({tag, "_st"}, 32'(store_commit_flag), 32'd0);
        check({tag, "_st_rename"}, 32'(store_commit_rename), 32'd0);
        check({tag, "_flush"}, 32'(register_flush), 32'd0);
        check({tag, "_flush_pc"}, flush_pc, 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        alloc_valid = 0; alloc_dest = 0; alloc_is_store = 0;
        alloc_is_branch = 0; alloc_pred_taken = 0; alloc_value = 0;
        simple_ins_commit = 0; simple_ins_rename = 0;
        cdb_valid = 0; cdb_rename = 0; cdb_value = 0;
        cdb_taken = 0; cdb_target = 0;

        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst = 1'b1;
        @(negedge clk);

        // In-order retire with out-of-order completion
        exp_q.push_back(mk_reg(5'd5, 32'h11, 4'd0));
        exp_q.push_back(mk_reg(5'd6, 32'h33, 4'd1));
        exp_q.push_back(mk_reg(5'd7, 32'h22, 4'd2));
        do_alloc(5'd5, 0, 0, 0, 32'h0);
        do_alloc(5'd6, 0, 0, 0, 32'h0);
        do_alloc(5'd7, 0, 0, 0, 32'h0);
        check("inorder_alloc_id", 32'(alloc_id), 32'd3);
        do_cdb(4'd2, 32'h22, 0, 32'h0);
        do_cdb(4'd0, 32'h11, 0, 32'h0);
        do_cdb(4'd1, 32'h33, 0, 32'h0);
        drain(20);

        // Asynchronous reset with 5 busy entries
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 0, 0, 0, 32'h0);
        check("pre_reset_alloc_id", 32'(alloc_id), 32'd8);
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_alloc_id", 32'(alloc_id), 32'd0);
        check("post_rst_full", 32'(rob_full), 32'd0);

        // Simple (lui) and store paths
        exp_q.push_back(mk_reg(5'd3, 32'hABCD0000, 4'd0));
        exp_q.push_back(mk_store(4'd1));
        do_alloc(5'd3, 0, 0, 0, 32'hABCD0000);
        do_alloc(5'd0, 1, 0, 0, 32'h0);
        do_simple(4'd0);
        do_cdb(4'd1, 32'hDEAD, 0, 32'h0);
        drain(20);
        repeat (2) @(negedge clk);

        // rdy stall with the head ready
        exp_q.push_back(mk_reg(5'd9, 32'h55, 4'd2));
        do_alloc(5'd9, 0, 0, 0, 32'h0);
        do_cdb(4'd2, 32'h55, 0, 32'h0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_commit", 32'(register_update_flag), 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        check("stall_release_commit", 32'(register_update_flag), 32'd1);
        drain(5);

        // Full and wrap
        sync_reset();
        for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 0, 0, 0, 32'h0);
        check("full_flag", 32'(rob_full), 32'd1);
        check("full_alloc_id", 32'(alloc_id), 32'd0);
        do_alloc(5'd31, 0, 0, 0, 32'hFFFF);
        check("full_ignore_id", 32'(alloc_id), 32'd0);
        check("full_ignore_flag", 32'(rob_full), 32'd1);
        exp_q.push_back(mk_reg(5'd1, 32'h100, 4'd0));
        do_cdb(4'd0, 32'h100, 0, 32'h0);
        @(negedge clk);
        check("after_commit_full", 32'(rob_full), 32'd0);
        check("after_commit_id", 32'(alloc_id), 32'd0);
        do_alloc(5'd20, 0, 0, 0, 32'h0);
        check("wrap_alloc_id", 32'(alloc_id), 32'd1);
        check("wrap_full", 32'(rob_full), 32'd1);
        drain(5);

        // Mispredicted branch at tag 3
        sync_reset();
        exp_q.push_back(mk_reg(5'd1, 32'h10, 4'd0));
        exp_q.push_back(mk_reg(5'd2, 32'h20, 4'd1));
        exp_q.push_back(mk_reg(5'd3, 32'h30, 4'd2));
        exp_q.push_back(mk_flush(32'h1040));
        do_alloc(5'd1, 0, 0, 0, 32'h0);
        do_alloc(5'd2, 0, 0, 0, 32'h0);
        do_alloc(5'd3, 0, 0, 0, 32'h0);
        do_alloc(5'd0, 0, 1, 0, 32'h0);
        do_alloc(5'd10, 0, 0, 0, 32'h0);
        do_alloc(5'd11, 0, 0, 0, 32'h0);
        do_cdb(4'd4, 32'h44, 0, 32'h0);
        do_cdb(4'd5, 32'h55, 0, 32'h0);
        do_cdb(4'd3, 32'h0, 1, 32'h1040);
        do_cdb(4'd0, 32'h10, 0, 32'h0);
        do_cdb(4'd1, 32'h20, 0, 32'h0);
        do_cdb(4'd2, 32'h30, 0, 32'h0);
        drain(20);
        repeat (4) @(negedge clk);
        check("flush_alloc_id", 32'(alloc_id), 32'd0);
        check("flush_full", 32'(rob_full), 32'd0);
        do_alloc(5'd12, 0, 0, 0, 32'h0);
        check("post_flush_alloc", 32'(alloc_id), 32'd1);
        repeat (3) @(negedge clk);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
